mmio_axi_master_bridge: RTL and testbench
=========================================

MMIO_AXI_MASTER_BRIDGE -- requirements
Module: mmio_axi_master_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the number of AXI wait cycles before a timeout response; a value of 0 disables the timeout.
REQ-002 SHALL have the following ports, clock and reset first:
- clock  in  1  sole clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted
- req_write  in  1  1=write, 0=read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes, errors and timeouts)
- rsp_resp  out  2  raw BRESP/RRESP (00 on timeout)
- rsp_err  out  1  resp!=00 or timeout
- rsp_timeout  out  1  transaction timed out
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  32/3/1/1  AXI-Lite AW channel
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  AXI-Lite W channel
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  AXI-Lite B channel
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  32/3/1/1  AXI-Lite AR channel
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  AXI-Lite R channel
REQ-003 SHALL drive awprot and arprot to 3'b000.

Function
REQ-004 SHALL implement the AXI FSM states IDLE, W_ADDR_DATA, W_RESP, R_ADDR and R_DATA, with at most one AXI transaction outstanding.
REQ-005 SHALL assert req_ready = (state==IDLE) && !rsp_valid; a command is accepted when req_valid && req_ready.
REQ-006 On write accept, SHALL register addr/wdata/wstrb, go to W_ADDR_DATA, and assert awvalid and wvalid together in the next cycle.
REQ-007 In W_ADDR_DATA, awvalid SHALL drop the cycle after awready is sampled high, and wvalid SHALL drop independently the cycle after wready is sampled high.
REQ-008 SHALL go to W_RESP when both AW and W have handshaken, including when both handshake in the same cycle.
REQ-009 SHALL assert bready only in W_RESP.
REQ-010 On read accept, SHALL register the address, go to R_ADDR, and assert arvalid until arready, then go to R_DATA.
REQ-011 SHALL assert rready only in R_DATA.
REQ-012 AXI valids SHALL never deassert before their ready, and addr/data/strb SHALL stay stable while valid is high.
REQ-013 On a B or R handshake, SHALL return to IDLE and, unless orphaned, load the response register; rsp_valid SHALL rise the next cycle.
REQ-014 Minimum write latency SHALL be: accept at cycle 0, aw/wvalid at 1, bready at 2, rsp_valid at 3 when slaves respond immediately; read latency SHALL match.
REQ-015 SHALL hold rsp_* stable while rsp_valid is high and clear rsp_valid the cycle after rsp_valid && rsp_ready.
REQ-016 Timeout counter: SHALL clear on accept, increment each cycle in any non-IDLE state, and saturate.
REQ-017 When TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES-1 without completion, SHALL assert in the next cycle rsp_valid=1, rsp_timeout=1, rsp_err=1, rsp_resp=00, rsp_rdata=0, and set an orphan flag.
REQ-018 With the orphan flag set, the AXI FSM SHALL continue until its handshake completes, discard the result, clear orphan and return to IDLE; req_ready stays low until both IDLE and the response has been consumed.
REQ-019 A completion in the same cycle the timeout threshold is reached SHALL win: a normal response with rsp_timeout=0.
REQ-020 rsp_err SHALL equal (resp!=2'b00) for normal completions; rsp_rdata SHALL be m_axi_rdata on reads and 0 on writes.

Reset
REQ-021 While reset=1 at a clock edge, SHALL force state=IDLE, orphan=0, counter=0, rsp_valid=0, all AXI valid/ready outputs=0, and rsp_*, addr and data registers=0.
REQ-022 Reset mid-transaction SHALL abandon it without issuing a response; the system resets the AXI slave concurrently.
REQ-023 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-024 Write 0x0000_0010 data 0xA5A5_5A5A strb 0xF, slave with zero-wait ready and bresp=00 -> aw/wvalid at cycle 1, rsp_valid at cycle 3, rsp_err=0, rsp_rdata=0.
REQ-025 Write with wready 3 cycles after awready -> awvalid drops after its handshake, wvalid is held 3 extra cycles, and exactly one B handshake occurs.
REQ-026 Read 0x0000_0020 with rdata 0x1234_5678 and rresp=10 -> rsp_rdata=0x1234_5678, rsp_resp=10, rsp_err=1.
REQ-027 TIMEOUT_CYCLES=8, slave never asserts arready -> rsp_timeout=1 after 8 cycles; a late arready/rvalid is consumed silently, then req_ready=1.
REQ-028 rsp_ready held low 5 cycles with a new req_valid pending -> rsp_* stable, req_ready=0, and the new command is accepted only after the response handshake.
REQ-029 Reset asserted while in W_RESP -> next cycle all valids/readies=0, rsp_valid=0, and no response is produced.

Source files
------------

// File: rtl/mmio_axi_master_bridge.sv
// MMIO request/response to AXI4-Lite master bridge with one transaction in flight.
// An optional wait-cycle timeout answers the requester early and drains the bus silently.
module mmio_axi_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR_DATA,
        W_RESP,
        R_ADDR,
        R_DATA
    } state_t;

    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic        orphan_q, orphan_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_resp_q, rsp_resp_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    logic accept;
    logic b_hs;
    logic r_hs;
    logic done;
    logic timeout_hit;

    assign req_ready   = (state_q == IDLE) && !rsp_valid_q;
    assign accept      = req_valid && req_ready;
    assign b_hs        = (state_q == W_RESP) && m_axi_bvalid;
    assign r_hs        = (state_q == R_DATA) && m_axi_rvalid;
    assign done        = b_hs || r_hs;
    // A completion landing on the threshold cycle beats the timeout.
    assign timeout_hit = TIMEOUT_EN && (state_q != IDLE) && !orphan_q && !done
                         && (cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        orphan_d      = orphan_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        if ((state_q != IDLE) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d  = '0;
                    addr_d = req_addr;
                    if (req_write) begin
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = W_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = R_ADDR;
                    end
                end
            end
            W_ADDR_DATA: begin
                // AW and W retire independently; move on once neither is still pending.
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
                    state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (m_axi_bvalid) begin
                    state_d = IDLE;
                end
            end
            R_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = R_DATA;
                end
            end
            R_DATA: begin
                if (m_axi_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done) begin
            orphan_d = 1'b0;
            if (!orphan_q) begin
                rsp_valid_d   = 1'b1;
                rsp_timeout_d = 1'b0;
                rsp_resp_d    = b_hs ? m_axi_bresp : m_axi_rresp;
                rsp_err_d     = b_hs ? (m_axi_bresp != 2'b00) : (m_axi_rresp != 2'b00);
                rsp_rdata_d   = b_hs ? 32'd0 : m_axi_rdata;
            end
        end else if (timeout_hit) begin
            orphan_d      = 1'b1;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_resp_d    = 2'b00;
            rsp_rdata_d   = 32'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            orphan_q      <= 1'b0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            orphan_q      <= orphan_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = (state_q == W_RESP);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = (state_q == R_DATA);

endmodule

// File: tb/tb_mmio_axi_master_bridge.sv
// Bench for mmio_axi_master_bridge: directed cases plus randomized slave latencies,
// with expected latency/response derived from handshake-delay arithmetic and the timeout rule.
module tb_mmio_axi_master_bridge;

    localparam int unsigned TO = 8;

    logic        clock;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_err, rsp_timeout;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    mmio_axi_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  bresp_v, rresp_v;
    logic [31:0] rdata_v;

    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit aw_got, w_got, b_pend, r_pend;
    int aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, r_hs_n;
    int aw_vcyc, w_vcyc;
    bit p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    bit          cur_write;
    int          accept_cyc, exp_lat;
    bit          exp_to, exp_err;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          base_aw, base_w, base_b, base_ar, base_r;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic slave_reset();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        p_aw = 0; p_w = 0; p_ar = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0;
        m_axi_rdata = 0;
    endtask

    // One clock: slave reacts at the falling edge, so handshakes are decided before the next rise.
    task automatic run_cycle();
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (p_aw) begin
            check_bit("awvalid_held", m_axi_awvalid, 1'b1);
            check_word("awaddr_stable", m_axi_awaddr, p_awaddr);
        end
        if (p_w) begin
            check_bit("wvalid_held", m_axi_wvalid, 1'b1);
            check_word("wdata_stable", m_axi_wdata, p_wdata);
            check_word("wstrb_stable", 32'(m_axi_wstrb), 32'(p_wstrb));
        end
        if (p_ar) begin
            check_bit("arvalid_held", m_axi_arvalid, 1'b1);
            check_word("araddr_stable", m_axi_araddr, p_araddr);
        end
        m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_d);
        m_axi_wready  = m_axi_wvalid && (w_cnt >= w_d);
        m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_d);
        m_axi_bvalid  = b_pend && (b_cnt >= b_d);
        m_axi_rvalid  = r_pend && (r_cnt >= r_d);
        m_axi_bresp   = bresp_v;
        m_axi_rresp   = rresp_v;
        m_axi_rdata   = m_axi_rvalid ? rdata_v : 32'd0;
        aw_hs = m_axi_awvalid && m_axi_awready;
        w_hs  = m_axi_wvalid && m_axi_wready;
        ar_hs = m_axi_arvalid && m_axi_arready;
        b_hs  = m_axi_bvalid && m_axi_bready;
        r_hs  = m_axi_rvalid && m_axi_rready;
        if (m_axi_awvalid) aw_vcyc++;
        if (m_axi_wvalid) w_vcyc++;
        if (m_axi_awvalid && !aw_hs) aw_cnt++;
        if (m_axi_wvalid && !w_hs) w_cnt++;
        if (m_axi_arvalid && !ar_hs) ar_cnt++;
        if (b_pend && !m_axi_bvalid) b_cnt++;
        if (r_pend && !m_axi_rvalid) r_cnt++;
        if (aw_hs) begin aw_cnt = 0; aw_got = 1; aw_hs_n++; end
        if (w_hs) begin w_cnt = 0; w_got = 1; w_hs_n++; end
        if (b_hs) begin b_pend = 0; b_hs_n++; end
        if (r_hs) begin r_pend = 0; r_hs_n++; end
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; end
        if (ar_hs) begin ar_cnt = 0; ar_hs_n++; r_pend = 1; r_cnt = 0; end
        p_aw = m_axi_awvalid && !aw_hs; p_awaddr = m_axi_awaddr;
        p_w  = m_axi_wvalid && !w_hs;   p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
        p_ar = m_axi_arvalid && !ar_hs; p_araddr = m_axi_araddr;
    endtask

    // Cycle (accept = 0) on which the final B/R handshake lands for the configured slave delays.
    function automatic int completion_cycle(input bit wr);
        if (wr) return ((aw_d > w_d) ? aw_d : w_d) + 2 + b_d;
        return 2 + ar_d + r_d;
    endfunction

    task automatic set_expect(input bit wr);
        int c;
        c = completion_cycle(wr);
        if (c <= int'(TO)) begin
            exp_lat   = c + 1;
            exp_to    = 0;
            exp_resp  = wr ? bresp_v : rresp_v;
            exp_err   = (exp_resp != 2'b00);
            exp_rdata = wr ? 32'd0 : rdata_v;
        end else begin
            exp_lat   = int'(TO) + 1;
            exp_to    = 1;
            exp_err   = 1;
            exp_resp  = 2'b00;
            exp_rdata = 32'd0;
        end
    endtask

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb);
        check_bit("req_ready_idle", req_ready, 1'b1);
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        cur_write = wr;
        set_expect(wr);
        accept_cyc = cyc;
        aw_vcyc = 0; w_vcyc = 0;
        base_aw = aw_hs_n; base_w = w_hs_n; base_b = b_hs_n; base_ar = ar_hs_n; base_r = r_hs_n;
        run_cycle();
        req_valid = 0;
        if (wr) begin
            check_bit("awvalid_cycle1", m_axi_awvalid, 1'b1);
            check_bit("wvalid_cycle1", m_axi_wvalid, 1'b1);
            check_word("awaddr", m_axi_awaddr, addr);
            check_word("wdata", m_axi_wdata, wdata);
            check_word("wstrb", 32'(m_axi_wstrb), 32'(strb));
            check_word("awprot", 32'(m_axi_awprot), 32'd0);
        end else begin
            check_bit("arvalid_cycle1", m_axi_arvalid, 1'b1);
            check_word("araddr", m_axi_araddr, addr);
            check_word("arprot", 32'(m_axi_arprot), 32'd0);
            check_bit("no_awvalid_on_read", m_axi_awvalid, 1'b0);
        end
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 40) begin
            run_cycle();
            n++;
        end
        check_bit("rsp_valid_seen", rsp_valid, 1'b1);
        check_word("rsp_latency", cyc - accept_cyc, exp_lat);
        check_bit("rsp_timeout", rsp_timeout, exp_to);
        check_bit("rsp_err", rsp_err, exp_err);
        check_word("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
        check_word("rsp_rdata", rsp_rdata, exp_rdata);
    endtask

    task automatic consume();
        rsp_ready = 1;
        run_cycle();
        rsp_ready = 0;
        check_bit("rsp_valid_cleared", rsp_valid, 1'b0);
    endtask

    task automatic settle();
        int n = 0;
        while (!req_ready && n < 30) begin
            run_cycle();
            check_bit("orphan_no_rsp", rsp_valid, 1'b0);
            n++;
        end
        check_bit("req_ready_after_txn", req_ready, 1'b1);
        if (cur_write) begin
            check_word("aw_handshakes", aw_hs_n - base_aw, 1);
            check_word("w_handshakes", w_hs_n - base_w, 1);
            check_word("b_handshakes", b_hs_n - base_b, 1);
        end else begin
            check_word("ar_handshakes", ar_hs_n - base_ar, 1);
            check_word("r_handshakes", r_hs_n - base_r, 1);
        end
    endtask

    task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r,
                             input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
        aw_d = aw; w_d = w; b_d = b; ar_d = ar; r_d = r;
        bresp_v = br; rresp_v = rr; rdata_v = rd;
    endtask

    task automatic full_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb);
        issue(wr, addr, wdata, strb);
        wait_rsp();
        consume();
        settle();
    endtask

    initial begin
        reset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        rsp_ready = 0;
        aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; ar_hs_n = 0; r_hs_n = 0;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'd0);
        slave_reset();

        repeat (3) run_cycle();
        check_bit("reset_rsp_valid", rsp_valid, 1'b0);
        check_bit("reset_awvalid", m_axi_awvalid, 1'b0);
        check_bit("reset_wvalid", m_axi_wvalid, 1'b0);
        check_bit("reset_arvalid", m_axi_arvalid, 1'b0);
        check_bit("reset_bready", m_axi_bready, 1'b0);
        check_bit("reset_rready", m_axi_rready, 1'b0);
        check_word("reset_rsp_rdata", rsp_rdata, 32'd0);
        check_word("reset_rsp_resp", 32'(rsp_resp), 32'd0);
        check_bit("reset_rsp_err", rsp_err, 1'b0);
        check_bit("reset_rsp_timeout", rsp_timeout, 1'b0);
        check_word("reset_awaddr", m_axi_awaddr, 32'd0);
        check_word("reset_wdata", m_axi_wdata, 32'd0);
        reset = 0;
        run_cycle();
        check_bit("req_ready_after_reset", req_ready, 1'b1);

        $display("[TB] zero-wait write");
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'd0);
        full_txn(1, 32'h0000_0010, 32'hA5A5_5A5A, 4'hF);

        $display("[TB] wready three cycles after awready");
        set_slave(0, 3, 0, 0, 0, 2'b00, 2'b00, 32'd0);
        full_txn(1, 32'h0000_0044, 32'h0BAD_F00D, 4'h3);
        check_word("awvalid_cycles", aw_vcyc, 1);
        check_word("wvalid_cycles", w_vcyc, 4);

        $display("[TB] read with SLVERR");
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h1234_5678);
        full_txn(0, 32'h0000_0020, 32'd0, 4'h0);

        $display("[TB] completion on the threshold cycle, then one cycle late");
        set_slave(0, 0, 0, 2, 4, 2'b00, 2'b01, 32'hCAFE_0001);
        full_txn(0, 32'h0000_0030, 32'd0, 4'h0);
        set_slave(0, 0, 0, 3, 4, 2'b00, 2'b01, 32'hCAFE_0002);
        full_txn(0, 32'h0000_0034, 32'd0, 4'h0);

        $display("[TB] arready never arrives until after the timeout");
        set_slave(0, 0, 0, 1000, 0, 2'b00, 2'b00, 32'hDEAD_BEEF);
        issue(0, 32'h0000_0040, 32'd0, 4'h0);
        wait_rsp();
        consume();
        repeat (3) begin
            run_cycle();
            check_bit("orphan_req_ready_low", req_ready, 1'b0);
        end
        ar_d = 0;
        settle();

        $display("[TB] response back-pressure with a command pending");
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h7777_1111);
        issue(0, 32'h0000_0050, 32'd0, 4'h0);
        wait_rsp();
        req_valid = 1; req_write = 1; req_addr = 32'h0000_0060;
        req_wdata = 32'h0102_0304; req_wstrb = 4'h5;
        repeat (5) begin
            run_cycle();
            check_bit("held_rsp_valid", rsp_valid, 1'b1);
            check_word("held_rsp_rdata", rsp_rdata, 32'h7777_1111);
            check_word("held_rsp_resp", 32'(rsp_resp), 32'd0);
            check_bit("held_req_ready", req_ready, 1'b0);
            check_bit("held_no_awvalid", m_axi_awvalid, 1'b0);
        end
        consume();
        settle();
        set_slave(0, 0, 0, 0, 0, 2'b11, 2'b00, 32'd0);
        full_txn(1, 32'h0000_0060, 32'h0102_0304, 4'h5);

        $display("[TB] reset while waiting for B");
        set_slave(0, 0, 5, 0, 0, 2'b00, 2'b00, 32'd0);
        issue(1, 32'h0000_0070, 32'hFFFF_0000, 4'hF);
        run_cycle();
        check_bit("in_w_resp_bready", m_axi_bready, 1'b1);
        reset = 1;
        slave_reset();
        run_cycle();
        reset = 0;
        check_bit("rst_awvalid", m_axi_awvalid, 1'b0);
        check_bit("rst_wvalid", m_axi_wvalid, 1'b0);
        check_bit("rst_arvalid", m_axi_arvalid, 1'b0);
        check_bit("rst_bready", m_axi_bready, 1'b0);
        check_bit("rst_rready", m_axi_rready, 1'b0);
        check_bit("rst_rsp_valid", rsp_valid, 1'b0);
        repeat (6) begin
            run_cycle();
            check_bit("rst_no_rsp", rsp_valid, 1'b0);
            check_bit("rst_req_ready", req_ready, 1'b1);
        end

        $display("[TB] randomized transactions");
        for (int i = 0; i < 24; i++) begin
            bit          wr;
            logic [31:0] a, d;
            wr = 1'($urandom_range(0, 1));
            a  = $urandom & 32'hFFFF_FFFC;
            d  = $urandom;
            set_slave(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), $urandom);
            full_txn(wr, a, d, 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
